writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: OUT_WIDTH, default 32, data width of a register write.
REQ-002 Parameter: DEPTH, default 4, number of queue entries; fixed at 4 for this revision.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 alu_valid  input  1  ALU result offered this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_wd  input  OUT_WIDTH  ALU result data.
REQ-008 lsu_valid  input  1  load result offered this cycle.
REQ-009 lsu_rd  input  5  load destination register.
REQ-010 lsu_wd  input  OUT_WIDTH  load data.
REQ-011 ready  output  1  queue accepts offers this cycle.
REQ-012 WE3  output  1  register file write enable.
REQ-013 A3  output  5  register file write address.
REQ-014 WD3  output  OUT_WIDTH  register file write data.
REQ-015 A1, A2  input  5 each  register file read addresses to check.
REQ-016 pend1, pend2  output  1 each  a queued write targets A1 / A2.
REQ-017 byp1, byp2  output  OUT_WIDTH each  data of the youngest queued write to A1 / A2; 0 when the matching pendN is 0.

Function
REQ-018 The queue is a circular FIFO of DEPTH entries {rd, wd} with head pointer, tail pointer and count (range 0..DEPTH).
REQ-019 ready = 1 when count <= DEPTH-2; ready is combinational from count only.
REQ-020 Enqueue happens only when ready = 1; offers made while ready = 0 are dropped with no state change.
REQ-021 An offer with rd = 0 is never enqueued.
REQ-022 When both offers are accepted in one cycle, the lsu entry is written at tail and the alu entry at tail+1, so the lsu entry is older.
REQ-023 When count > 0: WE3 = 1, A3 = head.rd, WD3 = head.wd (combinational), and the head entry is popped at the next edge.
REQ-024 When count = 0: WE3 = 0, A3 = 0, WD3 = 0; no same-cycle pass-through from offer to write port.
REQ-025 Each accepted entry reaches the write port no earlier than the cycle after acceptance, and one entry drains per cycle.
REQ-026 Simultaneous enqueue and pop in one cycle: count_next = count + accepted - popped; pointers wrap modulo DEPTH.
REQ-027 pendN = 1 when AN != 0 and any occupied entry, including the head, has rd = AN.
REQ-028 bypN returns the data of the youngest occupied matching entry; offers in the current cycle are not searched.
REQ-029 AN = 0 always gives pendN = 0 and bypN = 0.
REQ-030 Because ready needs two free entries, count never exceeds DEPTH-1; DEPTH-entry overflow is unreachable.

Reset
REQ-031 While rst = 1 at an edge: count = 0, head = 0, tail = 0, and all entries invalid.
REQ-032 After reset: ready = 1, WE3 = 0, A3 = 0, WD3 = 0, pend1 = pend2 = 0, byp1 = byp2 = 0.
REQ-033 rst has priority over simultaneous offers and pops.
REQ-034 Reset asserted mid-drain discards all queued entries; no WE3 pulse occurs in the cycle after reset.

Verification
REQ-035 Single write: alu_valid=1, rd=5, wd=0xDEAD_BEEF for 1 cycle -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; the cycle after that WE3=0.
REQ-036 Dual offer: lsu rd=3 wd=0x11 and alu rd=4 wd=0x22 in the same cycle -> writes A3=3 then A3=4 on consecutive cycles.
REQ-037 Back-pressure: offer two writes per cycle for 4 cycles -> ready falls when count=3, offers made while ready=0 are dropped, count never exceeds 3, and every accepted write drains in order.
REQ-038 Forwarding: enqueue rd=7 wd=0x1 then rd=7 wd=0x2, A1=7 -> pend1=1 and byp1=0x2 while both are queued, byp1=0x2 after the first pops, and pend1=0 after the second pops.
REQ-039 x0 handling: alu rd=0 wd=0xFF -> nothing enqueued and WE3 stays 0; A2=0 -> pend2=0.
REQ-040 Reset mid-drain: 3 entries queued, then rst=1 for 1 cycle -> next cycle WE3=0, ready=1, pend1=pend2=0.

Source files
------------

// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU and load results into a 4-entry FIFO
// that drains one write per cycle and exposes pending/forwarding lookups for two read ports.
module writeback_queue #(
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [4:0]           alu_rd,
    input  logic [OUT_WIDTH-1:0] alu_wd,
    input  logic                 lsu_valid,
    input  logic [4:0]           lsu_rd,
    input  logic [OUT_WIDTH-1:0] lsu_wd,
    output logic                 ready,
    output logic                 WE3,
    output logic [4:0]           A3,
    output logic [OUT_WIDTH-1:0] WD3,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    output logic                 pend1,
    output logic                 pend2,
    output logic [OUT_WIDTH-1:0] byp1,
    output logic [OUT_WIDTH-1:0] byp2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]           rd_r [DEPTH];
    logic [OUT_WIDTH-1:0] wd_r [DEPTH];
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic [CNT_W-1:0]     count_r;

    logic                 ready_s;
    logic                 acc_lsu_s;
    logic                 acc_alu_s;
    logic                 pop_s;
    logic [PTR_W-1:0]     alu_idx_s;

    // Acceptance, pop and slot selection; two free slots are required so both offers always fit.
    always_comb begin
        ready_s   = (count_r <= CNT_W'(DEPTH - 2));
        acc_lsu_s = ready_s && lsu_valid && (lsu_rd != 5'd0);
        acc_alu_s = ready_s && alu_valid && (alu_rd != 5'd0);
        pop_s     = (count_r != CNT_W'(0));
        alu_idx_s = acc_lsu_s ? (tail_r + PTR_W'(1)) : tail_r;
    end

    assign ready = ready_s;

    // Write port presents the head entry whenever the queue is non-empty.
    always_comb begin
        if (pop_s) begin
            WE3 = 1'b1;
            A3  = rd_r[head_r];
            WD3 = wd_r[head_r];
        end else begin
            WE3 = 1'b0;
            A3  = 5'd0;
            WD3 = {OUT_WIDTH{1'b0}};
        end
    end

    // Scan oldest to youngest so the last hit leaves the youngest matching data.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        byp1  = {OUT_WIDTH{1'b0}};
        byp2  = {OUT_WIDTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            logic             occ_v;
            logic             hit1_v;
            logic             hit2_v;
            logic [PTR_W-1:0] idx_v;
            idx_v  = head_r + PTR_W'(k);
            occ_v  = (k < int'(count_r));
            hit1_v = occ_v && (A1 != 5'd0) && (rd_r[idx_v] == A1);
            hit2_v = occ_v && (A2 != 5'd0) && (rd_r[idx_v] == A2);
            pend1  = pend1 | hit1_v;
            pend2  = pend2 | hit2_v;
            byp1   = hit1_v ? wd_r[idx_v] : byp1;
            byp2   = hit2_v ? wd_r[idx_v] : byp2;
        end
    end

    // Queue storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                rd_r[k] <= 5'd0;
                wd_r[k] <= {OUT_WIDTH{1'b0}};
            end
        end else begin
            if (acc_lsu_s) begin
                rd_r[tail_r] <= lsu_rd;
                wd_r[tail_r] <= lsu_wd;
            end
            if (acc_alu_s) begin
                rd_r[alu_idx_s] <= alu_rd;
                wd_r[alu_idx_s] <= alu_wd;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            tail_r  <= tail_r + PTR_W'(acc_lsu_s) + PTR_W'(acc_alu_s);
            count_r <= count_r + CNT_W'(acc_lsu_s) + CNT_W'(acc_alu_s) - CNT_W'(pop_s);
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_writeback_queue;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wd;
    logic        ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic        pend1;
    logic        pend2;
    logic [31:0] byp1;
    logic [31:0] byp2;

    writeback_queue #(.OUT_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
        .ready(ready), .WE3(WE3), .A3(A3), .WD3(WD3),
        .A1(A1), .A2(A2), .pend1(pend1), .pend2(pend2), .byp1(byp1), .byp2(byp2)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    ent_t mq[$];
    int   drain_log[$];
    bit   model_live = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_bp [6];

    logic        e_p1, e_p2;
    logic [31:0] e_d1, e_d2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_offers();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_wd = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_wd = 32'd0;
    endtask

    function automatic void model_fwd(input logic [4:0] a, output logic p, output logic [31:0] d);
        p = 1'b0;
        d = 32'd0;
        for (int k = 0; k < mq.size(); k++) begin
            if (a != 5'd0 && mq[k].rd == a) begin
                p = 1'b1;
                d = mq[k].wd;
            end
        end
    endfunction

    // Reference model: FIFO of accepted writes, updated at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            bit rdy;
            rdy = (mq.size() <= 2);
            if (mq.size() > 0) void'(mq.pop_front());
            if (rdy && lsu_valid && lsu_rd != 5'd0) mq.push_back('{lsu_rd, lsu_wd});
            if (rdy && alu_valid && alu_rd != 5'd0) mq.push_back('{alu_rd, alu_wd});
        end
    end

    // Compare all outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (model_live) begin
            chk("ready", 32'(ready), 32'(mq.size() <= 2));
            chk("WE3", 32'(WE3), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("A3", 32'(A3), 32'(mq[0].rd));
                chk("WD3", WD3, mq[0].wd);
            end else begin
                chk("A3_idle", 32'(A3), 32'd0);
                chk("WD3_idle", WD3, 32'd0);
            end
            model_fwd(A1, e_p1, e_d1);
            model_fwd(A2, e_p2, e_d2);
            chk("pend1", 32'(pend1), 32'(e_p1));
            chk("byp1", byp1, e_d1);
            chk("pend2", 32'(pend2), 32'(e_p2));
            chk("byp2", byp2, e_d2);
            if (mq.size() > 3) chk("model_count_le3", 32'(mq.size()), 32'd3);
            if (WE3 === 1'b1) drain_log.push_back(int'(A3));
        end
    end

    initial begin
        exp_bp = '{8, 9, 10, 11, 14, 15};
        rst = 1'b1;
        clear_offers();
        A1 = 5'd5;
        A2 = 5'd9;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_WE3", 32'(WE3), 32'd0);
        chk("rst_A3", 32'(A3), 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_pend1", 32'(pend1), 32'd0);
        chk("rst_pend2", 32'(pend2), 32'd0);
        chk("rst_byp1", byp1, 32'd0);

        // Single write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEAD_BEEF;
        tick();
        clear_offers();
        @(negedge clk);
        chk("single_WE3", 32'(WE3), 32'd1);
        chk("single_A3", 32'(A3), 32'd5);
        chk("single_WD3", WD3, 32'hDEAD_BEEF);
        chk("single_byp1", byp1, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        chk("single_WE3_after", 32'(WE3), 32'd0);

        // Dual offer: lsu is older
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wd = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h22;
        tick();
        clear_offers();
        @(negedge clk);
        chk("dual_A3_first", 32'(A3), 32'd3);
        chk("dual_WD3_first", WD3, 32'h11);
        tick();
        @(negedge clk);
        chk("dual_A3_second", 32'(A3), 32'd4);
        chk("dual_WD3_second", WD3, 32'h22);
        tick();
        @(negedge clk);
        chk("dual_WE3_done", 32'(WE3), 32'd0);

        // Back-pressure: two offers per cycle for four cycles
        drain_log.delete();
        for (int i = 0; i < 4; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(8 + 2 * i);     lsu_wd = 32'((8 + 2 * i) * 256);
            alu_valid = 1'b1; alu_rd = 5'(9 + 2 * i);     alu_wd = 32'((9 + 2 * i) * 256);
            tick();
            if (i == 1) chk("bp_ready_low", 32'(ready), 32'd0);
        end
        clear_offers();
        repeat (5) tick();
        chk("bp_drain_len", 32'(drain_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk("bp_drain_order", 32'(drain_log[k]), 32'(exp_bp[k]));
        end

        // Forwarding: two writes to x7, youngest wins
        A1 = 5'd7; A2 = 5'd3;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h2;
        tick();
        clear_offers();
        @(negedge clk);
        chk("fwd_pend1_both", 32'(pend1), 32'd1);
        chk("fwd_byp1_both", byp1, 32'h2);
        chk("fwd_pend2_miss", 32'(pend2), 32'd0);
        tick();
        @(negedge clk);
        chk("fwd_pend1_one", 32'(pend1), 32'd1);
        chk("fwd_byp1_one", byp1, 32'h2);
        tick();
        @(negedge clk);
        chk("fwd_pend1_none", 32'(pend1), 32'd0);
        chk("fwd_byp1_none", byp1, 32'd0);

        // x0 handling
        A2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFF;
        tick();
        clear_offers();
        @(negedge clk);
        chk("x0_WE3", 32'(WE3), 32'd0);
        chk("x0_pend2", 32'(pend2), 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_wd = 32'h66;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFF;
        tick();
        clear_offers();
        @(negedge clk);
        chk("x0_mixed_A3", 32'(A3), 32'd6);
        tick();
        @(negedge clk);
        chk("x0_mixed_WE3", 32'(WE3), 32'd0);

        // Reset mid-drain with offers present
        A1 = 5'd22; A2 = 5'd23;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_wd = 32'h20;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_wd = 32'h21;
        tick();
        lsu_rd = 5'd22; lsu_wd = 32'h22;
        alu_rd = 5'd23; alu_wd = 32'h23;
        tick();
        clear_offers();
        @(negedge clk);
        chk("rmd_pend1_pre", 32'(pend1), 32'd1);
        chk("rmd_ready_pre", 32'(ready), 32'd0);
        rst = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd24; lsu_wd = 32'h24;
        alu_valid = 1'b1; alu_rd = 5'd25; alu_wd = 32'h25;
        tick();
        rst = 1'b0;
        clear_offers();
        @(negedge clk);
        chk("rmd_WE3", 32'(WE3), 32'd0);
        chk("rmd_ready", 32'(ready), 32'd1);
        chk("rmd_pend1", 32'(pend1), 32'd0);
        chk("rmd_pend2", 32'(pend2), 32'd0);

        // Mixed traffic to exercise pointer wrap and partial acceptance
        for (int i = 0; i < 24; i++) begin
            lsu_valid = ((i % 3) != 0);
            lsu_rd    = 5'((i * 7) % 32);
            lsu_wd    = 32'(32'h1000 + i);
            alu_valid = ((i % 2) == 0);
            alu_rd    = 5'((i * 5 + 1) % 32);
            alu_wd    = 32'(32'h2000 + i);
            A1        = 5'(i % 8);
            A2        = 5'((i * 3) % 32);
            tick();
        end
        clear_offers();
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
